// File: rtl/xalu_pkg.sv
// XALU shared types: op codes, FSM states, divider constants.
// Imported by xalu_muldiv and xalu_div_iter.
package xalu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MUL   = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } xalu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER
  } xalu_state_t;

  localparam int DIV_ITERS = 32;

  function automatic logic op_is_signed(
    input xalu_op_t o
  );
    return (o == OP_MULT) || (o == OP_DIV) ||
           (o == OP_MADD) || (o == OP_MSUB);
  endfunction

endpackage

// File: rtl/xalu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports: clk, resetn, start/abort in, dividend/divisor in,
//        last (final iteration this cycle), quo_nxt/rem_nxt.
module xalu_div_iter
  import xalu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         last,
  output logic [W-1:0] quo_nxt,
  output logic [W-1:0] rem_nxt
);

  localparam int CW = $clog2(DIV_ITERS);

  logic          act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W:0]    trial;
  logic          ge;

  // quo_q doubles as the dividend shift register:
  // its MSB feeds the partial remainder each step.
  always_comb begin
    trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
    // zero divisor always "fits": q=all ones, r=dividend
    ge = (dvs_q == '0) || !trial[W];
    quo_nxt = {quo_q[W-2:0], ge};
    rem_nxt = ge ? trial[W-1:0]
                 : {rem_q[W-2:0], quo_q[W-1]};
  end

  assign last = act_q &&
                (cnt_q == CW'(DIV_ITERS - 1));

  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (abort) begin
      act_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      act_d = 1'b1;
      cnt_d = '0;
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (act_q) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
      cnt_d = cnt_q + 1'b1;
      act_d = !last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      act_q <= act_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/xalu_muldiv.sv
// Multi-cycle mul/div unit owning HI/LO (execute stage).
// Ports: clk, resetn, start/op/src_a/src_b/flush in;
//        busy, done, hi, lo, mul_result out.
// Build option: XALU_MADD_EN adds madd/maddu/msub/msubu.
module xalu_muldiv
  import xalu_pkg::*;
#(
  parameter int MULT_LATENCY = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mul_result
);

  localparam int W  = DATA_W;
  localparam int W2 = 2 * DATA_W;

  xalu_state_t  state_q, state_d;
  xalu_op_t     op_q, op_d;
  logic [3:0]   mcnt_q, mcnt_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0] mres_q, mres_d;
  logic         done_q, done_d;
  logic         sq_q, sq_d, sr_q, sr_d;

  logic         dec_mthi, dec_mtlo;
  logic         dec_mul, dec_div;
  logic         sgn;
  logic [W-1:0] abs_a, abs_b;
  logic [W2-1:0] prod_u, prod_s, prod;
  logic         div_start, div_last;
  logic [W-1:0] div_quo, div_rem;
  logic [W-1:0] q_fix, r_fix;

  always_comb begin
    dec_mthi = (op == OP_MTHI);
    dec_mtlo = (op == OP_MTLO);
    dec_div  = (op == OP_DIV) || (op == OP_DIVU);
    dec_mul  = (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_MUL);
`ifdef XALU_MADD_EN
    dec_mul  = dec_mul ||
               (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
`endif
  end

  assign sgn   = op_is_signed(op_q);
  assign abs_a = (sgn && a_q[W-1]) ? -a_q : a_q;
  assign abs_b = (sgn && b_q[W-1]) ? -b_q : b_q;

  // low 2W bits of the sign-extended product
  // equal the signed product
  assign prod_u = {{W{1'b0}}, a_q} *
                  {{W{1'b0}}, b_q};
  assign prod_s = {{W{a_q[W-1]}}, a_q} *
                  {{W{b_q[W-1]}}, b_q};
  assign prod   = sgn ? prod_s : prod_u;

  assign div_start = (state_q == ST_DIV_PREP) && !flush;

  xalu_div_iter #(
    .W (W)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start),
    .abort    (flush),
    .dividend (abs_a),
    .divisor  (abs_b),
    .last     (div_last),
    .quo_nxt  (div_quo),
    .rem_nxt  (div_rem)
  );

  assign q_fix = sq_q ? -div_quo : div_quo;
  assign r_fix = sr_q ? -div_rem : div_rem;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mcnt_d  = mcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mres_d  = mres_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          unique case (1'b1)
            dec_mthi: hi_d = src_a;
            dec_mtlo: lo_d = src_a;
            dec_mul: begin
              state_d = ST_MUL;
              mcnt_d  = 4'(MULT_LATENCY - 1);
              op_d    = xalu_op_t'(op);
              a_d     = src_a;
              b_d     = src_b;
            end
            dec_div: begin
              state_d = ST_DIV_PREP;
              op_d    = xalu_op_t'(op);
              a_d     = src_a;
              b_d     = src_b;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
          mcnt_d  = '0;
        end else if (mcnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          case (op_q)
            OP_MUL: mres_d = prod[W-1:0];
`ifdef XALU_MADD_EN
            OP_MADD, OP_MADDU:
              {hi_d, lo_d} = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU:
              {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
            default: {hi_d, lo_d} = prod;
          endcase
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end
      ST_DIV_PREP: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV_ITER;
          sq_d = sgn && (a_q[W-1] ^ b_q[W-1]);
          sr_d = sgn && a_q[W-1];
        end
      end
      ST_DIV_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (div_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          lo_d    = q_fix;
          hi_d    = r_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
      mcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mres_q  <= '0;
      done_q  <= 1'b0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mcnt_q  <= mcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mres_q  <= mres_d;
      done_q  <= done_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign mul_result = mres_q;

endmodule

// File: tb/tb_xalu_muldiv.sv
// Testbench for xalu_muldiv: vector table, corner sequences,
// random ops against an arithmetic reference model.
module tb_xalu_muldiv;
  import xalu_pkg::*;

  localparam int LAT = 4;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mul_result;

  xalu_muldiv #(
    .MULT_LATENCY (LAT),
    .DATA_W       (32)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .mul_result (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mres;
    int          bsy;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [31:0] mres_m = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h",
               nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the op rules.
  // Returns the expected number of busy cycles.
  function automatic int model_op(input logic [3:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    longint sa, sb;
    logic [63:0] pu;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      OP_MULT: begin
        {hi_m, lo_m} = 64'(sa * sb);
        return LAT;
      end
      OP_MULTU: begin
        {hi_m, lo_m} = pu;
        return LAT;
      end
      OP_MUL: begin
        mres_m = pu[31:0];
        return LAT;
      end
      OP_DIV: begin
        if (b == 0) begin
          lo_m = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          hi_m = a;
        end else if (a == 32'h8000_0000 &&
                     b == 32'hFFFF_FFFF) begin
          lo_m = a;
          hi_m = 0;
        end else begin
          lo_m = ia / ib;
          hi_m = ia % ib;
        end
        return 33;
      end
      OP_DIVU: begin
        if (b == 0) begin
          lo_m = 32'hFFFF_FFFF;
          hi_m = a;
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
        return 33;
      end
      OP_MTHI: begin
        hi_m = a;
        return 0;
      end
      OP_MTLO: begin
        lo_m = a;
        return 0;
      end
`ifdef XALU_MADD_EN
      OP_MADD: begin
        {hi_m, lo_m} = {hi_m, lo_m} + 64'(sa * sb);
        return LAT;
      end
      OP_MADDU: begin
        {hi_m, lo_m} = {hi_m, lo_m} + pu;
        return LAT;
      end
      OP_MSUB: begin
        {hi_m, lo_m} = {hi_m, lo_m} - 64'(sa * sb);
        return LAT;
      end
      OP_MSUBU: begin
        {hi_m, lo_m} = {hi_m, lo_m} - pu;
        return LAT;
      end
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op, then count busy cycles until idle.
  // Leaves the caller at the negedge where busy=0.
  task automatic run_op(input logic [3:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int bc,
                        output logic dn);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    op    = 4'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    dn = done;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [4];
    sp[0] = 32'h0;
    sp[1] = 32'h8000_0000;
    sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h1;
    if ($urandom_range(0, 3) == 0)
      return sp[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    int bc;
    logic dn;
    int lat;
    logic [3:0] o;
    logic [31:0] a, b;

    tbl.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h1, 32'h0, 4});
    tbl.push_back('{OP_DIV, 32'hFFFFFFF9, 32'h2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 33});
    tbl.push_back('{OP_DIVU, 32'h5, 32'h0,
                    32'h5, 32'hFFFFFFFF, 32'h0, 33});
    tbl.push_back('{OP_MTHI, 32'h1234, 32'h0,
                    32'h1234, 32'hFFFFFFFF, 32'h0, 0});
    tbl.push_back('{OP_MTLO, 32'hCAFE, 32'h0,
                    32'h1234, 32'hCAFE, 32'h0, 0});
    tbl.push_back('{OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                    32'h0, 32'h80000000, 32'h0, 33});
    tbl.push_back('{OP_MUL, 32'h7, 32'hFFFFFFFD,
                    32'h0, 32'h80000000, 32'hFFFFFFEB, 4});
    tbl.push_back('{OP_MULT, 32'hFFFFFFFE, 32'h3,
                    32'hFFFFFFFF, 32'hFFFFFFFA,
                    32'hFFFFFFEB, 4});
    tbl.push_back('{4'hF, 32'h11, 32'h22,
                    32'hFFFFFFFF, 32'hFFFFFFFA,
                    32'hFFFFFFEB, 0});
    tbl.push_back('{OP_DIV, 32'hFFFFFFF6, 32'h0,
                    32'hFFFFFFF6, 32'h1, 32'hFFFFFFEB, 33});
    tbl.push_back('{OP_DIVU, 32'd100, 32'd7,
                    32'h2, 32'hE, 32'hFFFFFFEB, 33});
    tbl.push_back('{OP_MTHI, 32'h0, 32'h0,
                    32'h0, 32'hE, 32'hFFFFFFEB, 0});
    tbl.push_back('{OP_MTLO, 32'h10, 32'h0,
                    32'h0, 32'h10, 32'hFFFFFFEB, 0});
`ifdef XALU_MADD_EN
    tbl.push_back('{OP_MADD, 32'h3, 32'h4,
                    32'h0, 32'h1C, 32'hFFFFFFEB, 4});
    tbl.push_back('{OP_MSUBU, 32'h1, 32'h1D,
                    32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFEB, 4});
`else
    tbl.push_back('{OP_MADD, 32'h3, 32'h4,
                    32'h0, 32'h10, 32'hFFFFFFEB, 0});
    tbl.push_back('{OP_MSUBU, 32'h1, 32'h1D,
                    32'h0, 32'h10, 32'hFFFFFFEB, 0});
`endif

    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = '0;
    src_a  = '0;
    src_b  = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mres", mul_result, 0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, bc, dn);
      void'(model_op(tbl[i].op, tbl[i].a, tbl[i].b));
      chk($sformatf("t%0d_busy", i), bc, tbl[i].bsy);
      chk($sformatf("t%0d_done", i), dn,
          tbl[i].bsy != 0);
      chk($sformatf("t%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("t%0d_lo", i), lo, tbl[i].lo);
      chk($sformatf("t%0d_mres", i), mul_result,
          tbl[i].mres);
      @(negedge clk);
      chk($sformatf("t%0d_pulse", i), done, 0);
    end

    // flush a divide on busy cycle 10
    run_op(OP_MTHI, 32'hAAAA, 0, bc, dn);
    run_op(OP_MTLO, 32'h5555, 0, bc, dn);
    void'(model_op(OP_MTHI, 32'hAAAA, 0));
    void'(model_op(OP_MTLO, 32'h5555, 0));
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("fl_div_busy10", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_div_busy", busy, 0);
    chk("fl_div_done", done, 0);
    chk("fl_div_hi", hi, 32'hAAAA);
    chk("fl_div_lo", lo, 32'h5555);
    @(negedge clk);
    chk("fl_div_done2", done, 0);

    // flush in the final multiply cycle
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    src_a = 32'd6;
    src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    chk("fl_mul_busylast", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_mul_busy", busy, 0);
    chk("fl_mul_done", done, 0);
    chk("fl_mul_hi", hi, 32'hAAAA);
    chk("fl_mul_lo", lo, 32'h5555);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    src_a = 32'd3;
    src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      if (bc == 2) begin
        start = 1'b1;
        op    = OP_MULT;
        src_a = 32'd9;
        src_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    void'(model_op(OP_MULT, 32'd3, 32'd5));
    chk("ign_busy", bc, LAT);
    chk("ign_done", done, 1);
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 32'd15);
    @(negedge clk);
    chk("ign_idle", busy, 0);
    chk("ign_lo2", lo, 32'd15);

    // flush blocks start while idle
    start = 1'b1;
    flush = 1'b1;
    op    = OP_MTHI;
    src_a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("fl_start_hi", hi, 0);
    chk("fl_start_busy", busy, 0);

    // async reset mid-division
    run_op(OP_MTHI, 32'h77, 0, bc, dn);
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    src_a = 32'd1000;
    src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("rs_busy20", busy, 1);
    chk("rs_prehi", hi, 32'h77);
    #1 resetn = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_hi", hi, 0);
    chk("rs_lo", lo, 0);
    chk("rs_mres", mul_result, 0);
    @(negedge clk);
    resetn = 1'b1;
    hi_m   = '0;
    lo_m   = '0;
    mres_m = '0;

    for (int k = 0; k < 150; k++) begin
      o = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      run_op(o, a, b, bc, dn);
      lat = model_op(o, a, b);
      chk($sformatf("r%0d_op%0d_busy", k, o), bc, lat);
      chk($sformatf("r%0d_done", k), dn, lat != 0);
      chk($sformatf("r%0d_hi", k), hi, hi_m);
      chk($sformatf("r%0d_lo", k), lo, lo_m);
      chk($sformatf("r%0d_mres", k), mul_result,
          mres_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
Multi-cycle multiply/divide unit (XALU) for the execute stage. It owns the architectural HI/LO registers and executes mult/multu/div/divu/mul/mthi/mtlo. Its busy output feeds the hazard/stall unit, which stalls any HI/LO-family instruction in decode while the XALU is occupied. An exception flush aborts any in-flight operation without committing HI/LO.

Parameters:
MULT_LATENCY, 4, cycles busy for mult/multu/mul (legal range 1..8)
DATA_W, 32, operand and HI/LO width

Ports:
clk  in  1  clock (rising edge)
resetn  in  1  asynchronous active-low reset
start  in  1  issue request; sampled only when busy=0
op  in  4  xalu_op_t operation code
src_a  in  32  rs operand
src_b  in  32  rt operand
flush  in  1  exception flush; aborts in-flight op, blocks start
busy  out  1  operation in flight; drives the stall unit's XALU_Busy input
done  out  1  one-cycle pulse in the cycle results commit
hi  out  32  architectural HI
lo  out  32  architectural LO
mul_result  out  32  low product of last mul; valid when done=1

Behaviour:
- Reset (async, resetn=0): hi=0, lo=0, busy=0, done=0, mul_result=0, FSM=IDLE, counter=0.
- FSM states: IDLE, MUL, DIV_PREP, DIV_ITER.
- Accept condition: start && !busy && !flush. When busy=1, start is ignored; the stall unit guarantees no issue.
- mthi/mtlo: commit at the accept edge (hi<=src_a or lo<=src_a). busy stays 0 and done does not pulse.
- mult/multu/mul: IDLE->MUL at the accept edge. busy=1 for exactly MULT_LATENCY cycles. At the final MUL edge, commit and go to IDLE with done=1 for one cycle.
  - mult/multu write {hi,lo} <= 64-bit product (signed/unsigned).
  - mul writes mul_result <= product[31:0]; hi/lo are unchanged.
- div/divu: IDLE->DIV_PREP, which computes absolute values and latches sign flags.
  - DIV_PREP->DIV_ITER runs 32 restoring iterations, one quotient bit per cycle. busy=1 for 33 cycles total.
  - After iteration 32: lo<=quotient, hi<=remainder, done=1, go to IDLE.
  - Signed rules: quotient sign = sign(a) xor sign(b); remainder takes the sign of a.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero is deterministic: magnitude quotient=0xFFFFFFFF and remainder=|a|. Sign correction applies only in signed mode.
- Operands are latched at accept. Later changes on src_a/src_b have no effect.
- Flush while busy: the next edge goes to IDLE, busy=0, done=0, and hi/lo/mul_result keep their pre-op values.
  - Flush in the exact commit cycle (final MUL or iteration 32) also suppresses the commit.
- done is never asserted in the same cycle as busy=0 following an abort.
- Undefined op codes are accepted as NOP: no state change, busy stays 0.

Optional Feature:
XALU_MADD_EN: when defined, adds the madd/maddu/msub/msubu op codes.
- These use the MUL path and latency.
- At commit: {hi,lo} <= {hi,lo} ± product (64-bit wrap; signed/unsigned product per op).
- When undefined, these codes decode as NOP and the accumulate adder is not synthesized.

Decomposition:
- Package xalu_pkg holds:
  - xalu_op_t enum (4-bit): OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MUL, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  - state enum
  - DIV_ITERS=32
- Sub-module xalu_div_iter contains the restoring divider datapath plus its iteration counter, with start/abort/done handshake. The top module holds the FSM, multiplier pipeline/counter, and the HI/LO registers.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> busy 4 cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7) b=2 -> busy 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 5/0 -> lo=0xFFFFFFFF, hi=5.
- Preload hi=0xAAAA, lo=0x5555; start divu 100/7; assert flush on busy cycle 10 -> busy=0 next cycle, no done; hi=0xAAAA, lo=0x5555.
- mthi src_a=0x1234 while idle -> hi=0x1234 after one edge, busy never 1. Start mult while busy -> ignored, result equals the first op only.
- Assert resetn=0 mid-division (cycle 20) -> hi=lo=0 and busy=0 immediately, without waiting for a clock edge.
- XALU_MADD_EN defined: hi:lo=0x0:0x10, madd 3,4 -> lo=0x1C, hi=0. msubu 1,0x1D -> hi:lo=0xFFFFFFFF:0xFFFFFFFF.
